// File: rtl/mem_port_arbiter.sv
// Merges the fetch read channel and the data read/write channel onto one shared
// memory port, one transaction in flight, round-robin on ties.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_rdata,
    input  logic              d_req_re,
    input  logic              d_req_we,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [MASK_W-1:0] d_req_wmask,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_rdata,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic              m_req_we,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [DATA_W-1:0] m_req_wdata,
    output logic [MASK_W-1:0] m_req_wmask,
    input  logic              m_rsp_valid,
    input  logic [DATA_W-1:0] m_rsp_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              last_d;
    logic              owner_d;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [MASK_W-1:0] cap_wmask;
    logic [DATA_W-1:0] i_rdata;
    logic [DATA_W-1:0] d_rdata;

    logic i_act, d_act, idle_live, grant_i, grant_d;

    assign i_act     = i_req_valid;
    assign d_act     = d_req_re | d_req_we;
    assign idle_live = !rst && (state == IDLE);
    // On a tie the side that did not win the previous transaction goes first.
    assign grant_d   = idle_live && d_act && (!i_act || !last_d);
    assign grant_i   = idle_live && i_act && !(d_act && !last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            owner_d   <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wmask <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d   <= 1'b1;
                        cap_we    <= d_req_we;
                        cap_addr  <= d_req_addr;
                        cap_wdata <= d_req_wdata;
                        cap_wmask <= d_req_we ? d_req_wmask : '0;
                        state     <= ISSUE;
                    end else if (grant_i) begin
                        owner_d   <= 1'b0;
                        cap_we    <= 1'b0;
                        cap_addr  <= i_req_addr;
                        cap_wdata <= '0;
                        cap_wmask <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: if (m_req_ready) state <= WAIT;
                WAIT: begin
                    if (m_rsp_valid) begin
                        if (owner_d) d_rdata <= cap_we ? '0 : m_rsp_rdata;
                        else         i_rdata <= m_rsp_rdata;
                        state <= RESP;
                    end
                end
                RESP: begin
                    last_d <= owner_d;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything is forced low while reset is asserted, even before the state settles.
    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;
    assign m_req_valid = !rst && (state == ISSUE);
    assign m_req_we    = !rst && cap_we;
    assign m_req_addr  = rst ? '0 : cap_addr;
    assign m_req_wdata = rst ? '0 : cap_wdata;
    assign m_req_wmask = rst ? '0 : cap_wmask;
    assign i_rsp_valid = !rst && (state == RESP) && !owner_d;
    assign d_rsp_valid = !rst && (state == RESP) && owner_d;
    assign i_rsp_rdata = rst ? '0 : i_rdata;
    assign d_rsp_rdata = rst ? '0 : d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset corner sequences and
// random transactions checked against a transaction-level round-robin model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_rsp_valid;
    logic [63:0] i_req_addr, i_rsp_rdata;
    logic        d_req_re, d_req_we, d_req_ready, d_rsp_valid;
    logic [63:0] d_req_addr, d_req_wdata, d_rsp_rdata;
    logic [7:0]  d_req_wmask;
    logic        m_req_valid, m_req_ready, m_req_we, m_rsp_valid;
    logic [63:0] m_req_addr, m_req_wdata, m_rsp_rdata;
    logic [7:0]  m_req_wmask;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic model_last_d;  // 1 = data side won the previous completed transaction

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
        .d_req_re(d_req_re), .d_req_we(d_req_we), .d_req_ready(d_req_ready),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata)
    );

    typedef struct packed {
        logic        iv;
        logic [63:0] ia;
        logic        dre;
        logic        dwe;
        logic [63:0] da;
        logic [63:0] wd;
        logic [7:0]  wm;
        logic [63:0] rd;
        logic [3:0]  dly;
        logic        spur;
        logic        exp_d;
        logic [63:0] exp_rsp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    task automatic idle_inputs();
        i_req_valid = 0; i_req_addr = 0;
        d_req_re = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_req_wmask = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_i_ready"}, i_req_ready, 0);
        chk({nm, "_d_ready"}, d_req_ready, 0);
        chk({nm, "_m_valid"}, m_req_valid, 0);
        chk({nm, "_m_we"}, m_req_we, 0);
        chk({nm, "_m_addr"}, m_req_addr, 0);
        chk({nm, "_m_wmask"}, m_req_wmask, 0);
        chk({nm, "_i_rsp_valid"}, i_rsp_valid, 0);
        chk({nm, "_d_rsp_valid"}, d_rsp_valid, 0);
        chk({nm, "_i_rdata"}, i_rsp_rdata, 0);
        chk({nm, "_d_rdata"}, d_rsp_rdata, 0);
    endtask

    task automatic chk_req(input vec_t v);
        logic        ewe;
        logic [63:0] ea;
        ewe = v.exp_d && v.dwe;
        ea  = v.exp_d ? v.da : v.ia;
        chk("m_valid", m_req_valid, 1);
        chk("m_we", m_req_we, ewe);
        chk("m_addr", m_req_addr, ea);
        chk("m_wmask", m_req_wmask, ewe ? v.wm : 8'h0);
        if (ewe) chk("m_wdata", m_req_wdata, v.wd);
        chk("rsp_quiet_i", i_rsp_valid, 0);
        chk("rsp_quiet_d", d_rsp_valid, 0);
    endtask

    // One full transaction starting from IDLE; the grant is expected in the drive cycle.
    task automatic do_txn(input vec_t v);
        @(posedge clk); #1;
        i_req_valid = v.iv; i_req_addr = v.ia;
        d_req_re = v.dre; d_req_we = v.dwe; d_req_addr = v.da;
        d_req_wdata = v.wd; d_req_wmask = v.wm;
        m_req_ready = 0; m_rsp_valid = 0;
        @(negedge clk);
        chk("i_ready", i_req_ready, !v.exp_d);
        chk("d_ready", d_req_ready, v.exp_d);
        chk("m_valid_idle", m_req_valid, 0);
        @(posedge clk); #1;
        idle_inputs();
        m_req_ready = (v.dly == 0);
        @(negedge clk);
        chk_req(v);
        for (int c = 1; c <= int'(v.dly); c++) begin
            @(posedge clk); #1;
            m_req_ready = (c == int'(v.dly));
            m_rsp_valid = v.spur && (c == 1);
            m_rsp_rdata = ~v.rd;
            @(negedge clk);
            chk_req(v);
        end
        @(posedge clk); #1;
        m_req_ready = 0; m_rsp_valid = 1; m_rsp_rdata = v.rd;
        @(negedge clk);
        chk("m_valid_wait", m_req_valid, 0);
        chk("wait_i_rsp", i_rsp_valid, 0);
        chk("wait_d_rsp", d_rsp_valid, 0);
        @(posedge clk); #1;
        m_rsp_valid = 0; m_rsp_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk("i_rsp_valid", i_rsp_valid, !v.exp_d);
        chk("d_rsp_valid", d_rsp_valid, v.exp_d);
        if (v.exp_d) chk("d_rsp_rdata", d_rsp_rdata, v.exp_rsp);
        else         chk("i_rsp_rdata", i_rsp_rdata, v.exp_rsp);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_i_rsp", i_rsp_valid, 0);
        chk("post_d_rsp", d_rsp_valid, 0);
        if (v.exp_d) chk("d_rdata_hold", d_rsp_rdata, v.exp_rsp);
        else         chk("i_rdata_hold", i_rsp_rdata, v.exp_rsp);
        model_last_d = v.exp_d;
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        // iv ia dre dwe da wd wm rd dly spur exp_d exp_rsp
        tbl[0] = '{1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00,
                   64'h00000013_00500093, 4'd0, 1'b0, 1'b0, 64'h00000013_00500093};
        tbl[1] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'h2004, 64'hDEADBEEF_00000000, 8'hF0,
                   64'h1234, 4'd0, 1'b0, 1'b1, 64'h0};
        tbl[2] = '{1'b1, 64'h3000, 1'b1, 1'b0, 64'h4000, 64'h0, 8'h00,
                   64'hAAAA_0001, 4'd0, 1'b0, 1'b0, 64'hAAAA_0001};
        tbl[3] = '{1'b1, 64'h3008, 1'b1, 1'b0, 64'h4008, 64'h0, 8'hFF,
                   64'hBBBB_0002, 4'd1, 1'b0, 1'b1, 64'hBBBB_0002};
        tbl[4] = '{1'b1, 64'h3010, 1'b0, 1'b1, 64'h4010, 64'h77, 8'h01,
                   64'hCCCC_0003, 4'd0, 1'b0, 1'b0, 64'hCCCC_0003};
        tbl[5] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h8, 64'h5555_5555_5555_5555, 8'h0F,
                   64'h9999, 4'd0, 1'b0, 1'b1, 64'h0};
        tbl[6] = '{1'b1, 64'h40, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00,
                   64'hFEED_FACE, 4'd5, 1'b1, 1'b0, 64'hFEED_FACE};
        tbl[7] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h100, 64'hFFFF, 8'hFF,
                   64'h0BAD_CAFE, 4'd2, 1'b1, 1'b1, 64'h0BAD_CAFE};
        // after the mid-transaction reset: tie goes to D, then to the fetch at 0x0
        tbl[8] = '{1'b1, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0, 8'h00,
                   64'h1111, 4'd0, 1'b0, 1'b1, 64'h1111};
        tbl[9] = '{1'b1, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0, 8'h00,
                   64'h2222, 4'd0, 1'b0, 1'b0, 64'h2222};

        idle_inputs();
        m_req_ready = 0; m_rsp_valid = 0; m_rsp_rdata = 0;
        rst = 1;
        i_req_valid = 1; d_req_we = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 0; idle_inputs();
        model_last_d = 0;

        for (int k = 0; k < 8; k++) do_txn(tbl[k]);

        // Reset while waiting for the response, then a stale response arrives.
        @(posedge clk); #1;
        i_req_valid = 1; i_req_addr = 64'h500;
        @(negedge clk);
        chk("mr_i_ready", i_req_ready, 1);
        @(posedge clk); #1;
        idle_inputs(); m_req_ready = 1;
        @(negedge clk);
        chk("mr_m_valid", m_req_valid, 1);
        @(posedge clk); #1;
        m_req_ready = 0;
        @(negedge clk);
        chk("mr_wait", m_req_valid, 0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        rst = 0; m_rsp_valid = 1; m_rsp_rdata = 64'hBAD;
        @(negedge clk);
        chk("stale_i_rsp", i_rsp_valid, 0);
        chk("stale_d_rsp", d_rsp_valid, 0);
        chk("stale_i_rdata", i_rsp_rdata, 0);
        @(posedge clk); #1;
        m_rsp_valid = 0;
        @(negedge clk);
        chk("stale_i_rsp2", i_rsp_valid, 0);
        chk("stale_m_valid", m_req_valid, 0);
        model_last_d = 0;

        do_txn(tbl[8]);
        do_txn(tbl[9]);

        // Random traffic against the round-robin model.
        for (int n = 0; n < 40; n++) begin
            rv.iv  = 1'($urandom_range(0, 1));
            rv.dre = 1'($urandom_range(0, 1));
            rv.dwe = 1'($urandom_range(0, 1));
            if (!rv.iv && !rv.dre && !rv.dwe) rv.iv = 1;
            rv.ia = {$urandom, $urandom};
            rv.da = {$urandom, $urandom};
            rv.wd = {$urandom, $urandom};
            rv.wm = 8'($urandom);
            rv.rd = {$urandom, $urandom};
            rv.dly = 4'($urandom_range(0, 3));
            rv.spur = 1'($urandom_range(0, 1));
            if (rv.iv && (rv.dre || rv.dwe)) rv.exp_d = !model_last_d;
            else                             rv.exp_d = !rv.iv;
            rv.exp_rsp = (rv.exp_d && rv.dwe) ? 64'h0 : rv.rd;
            do_txn(rv);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
